// File: rtl/uart_rx_stream.sv
// UART 8N1 receiver with a small byte FIFO and a valid/ready output stream.
// Framing errors and overruns are reported as single-cycle registered pulses.
module uart_rx_stream #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    logic          rx_meta_q, rx_s_q;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          frame_err_q;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic          overrun_q;

    logic push, pop, full, push_ok;

    // Two-flop synchroniser for the asynchronous RX pin, idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame deserialiser: start qualified at mid-bit, then one sample per bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (!rx_s_q) state_q <= StStart;
                end
                StStart: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end else begin
                            state_q   <= StData;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StData: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= StStop;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StStop: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= '0;
                        // Leaving at mid-stop gives half a bit of slack to catch the next start.
                        if (rx_s_q) begin
                            state_q <= StIdle;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= StBreak;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                StBreak: begin
                    cnt_q <= '0;
                    if (rx_s_q) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // A good stop sample hands the assembled byte to the FIFO on the same edge.
    assign push    = (state_q == StStop) && (cnt_q == LAST_CNT) && rx_s_q;
    assign pop     = (count_q != '0) && i_ready;
    assign full    = (count_q == FULL_CNT);
    assign push_ok = push && (!full || pop);

    // Byte FIFO; a push into a full FIFO is only accepted if the head leaves this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= push && full && !pop;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_ok && !pop)      count_q <= count_q + (PW + 1)'(1);
            else if (!push_ok && pop) count_q <= count_q - (PW + 1)'(1);
        end
    end

    assign o_data      = mem_q[rd_ptr_q];
    assign o_valid     = (count_q != '0);
    assign o_busy      = (state_q != StIdle);
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream with a byte scoreboard fed by the stimulus.
module tb_uart_rx_stream;

    localparam int unsigned CPB   = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk, rst, i_rx, i_ready;
    logic [7:0] o_data;
    logic       o_valid, o_busy, o_frame_err, o_overrun;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int valid_cycles = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    logic busy_seen = 1'b0;
    logic [7:0] exp_q [$];

    uart_rx_stream #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (i_rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_busy     (o_busy),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive the first n_cyc cycles of an 8N1 frame; the stop level persists past cycle 72.
    task automatic send(input logic [7:0] b, input logic stop_bit, input int ready_at,
                        input int n_cyc);
        for (int c = 0; c < n_cyc; c++) begin
            if (c < 8)       i_rx = 1'b0;
            else if (c < 72) i_rx = b[(c / 8) - 1];
            else             i_rx = stop_bit;
            if (c == ready_at) i_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        i_rx = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: pops the scoreboard on every accepted byte and tallies pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_valid && i_ready) begin
                pops++;
                checks++;
                assert (exp_q.size() > 0) else begin
                    errors++;
                    $error("FAIL pop_unexpected observed=%02h expected=none", o_data);
                end
                if (exp_q.size() > 0) chk("pop_data", {24'd0, o_data}, {24'd0, exp_q.pop_front()});
            end
            if (o_valid) valid_cycles++;
            if (o_frame_err) ferr_cnt++;
            if (o_overrun) ovr_cnt++;
            if (o_busy) busy_seen = 1'b1;
            if (o_frame_err || o_overrun) chk("err_exclusive", {31'd0, o_frame_err & o_overrun}, 0);
        end
    end

    initial begin
        rst = 1'b1;
        i_rx = 1'b1;
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {31'd0, o_valid}, 0);
        chk("rst_data", {24'd0, o_data}, 0);
        chk("rst_busy", {31'd0, o_busy}, 0);
        chk("rst_ferr", {31'd0, o_frame_err}, 0);
        chk("rst_ovr", {31'd0, o_overrun}, 0);
        idle(2);

        // Single clean frame with the consumer ready.
        i_ready = 1'b1;
        valid_cycles = 0;
        exp_q.push_back(8'h55);
        send(8'h55, 1'b1, -1, 80);
        @(negedge clk);
        chk("t1_valid_after_stop", {31'd0, o_valid}, 1);
        chk("t1_data", {24'd0, o_data}, 32'h55);
        idle(10);
        chk("t1_valid_cycles", valid_cycles, 1);
        chk("t1_ferr", ferr_cnt, 0);
        chk("t1_ovr", ovr_cnt, 0);

        // Glitch shorter than half a bit.
        busy_seen = 1'b0;
        valid_cycles = 0;
        i_rx = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        idle(12);
        chk("t2_busy_seen", {31'd0, busy_seen}, 1);
        chk("t2_busy_fell", {31'd0, o_busy}, 0);
        chk("t2_no_valid", valid_cycles, 0);
        chk("t2_ferr", ferr_cnt, 0);

        // Bad stop bit with an extended low line, then recovery.
        valid_cycles = 0;
        send(8'hA3, 1'b0, -1, 96);
        idle(16);
        chk("t3_ferr", ferr_cnt, 1);
        chk("t3_no_valid", valid_cycles, 0);
        exp_q.push_back(8'h3C);
        send(8'h3C, 1'b1, -1, 80);
        idle(4);
        chk("t3_ferr_once", ferr_cnt, 1);
        chk("t3_valid_cycles", valid_cycles, 1);
        chk("t3_sb_empty", exp_q.size(), 0);

        // Overrun on the fifth back-to-back frame with the consumer stalled.
        i_ready = 1'b0;
        pops = 0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send(8'(i), 1'b1, -1, 80);
        end
        chk("t4_no_early_ovr", ovr_cnt, 0);
        send(8'h05, 1'b1, -1, 80);
        idle(2);
        chk("t4_ovr", ovr_cnt, 1);
        chk("t4_valid_full", {31'd0, o_valid}, 1);
        i_ready = 1'b1;
        idle(8);
        chk("t4_pops", pops, 4);
        chk("t4_drained", {31'd0, o_valid}, 0);
        chk("t4_sb_empty", exp_q.size(), 0);

        // Full FIFO with a pop on the stop-sample cycle of the fifth frame.
        i_ready = 1'b0;
        pops = 0;
        ovr_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h10 + 8'(i));
            send(8'h10 + 8'(i), 1'b1, -1, 80);
        end
        exp_q.push_back(8'h14);
        send(8'h14, 1'b1, 79, 80);
        i_ready = 1'b0;
        idle(2);
        chk("t5_no_ovr", ovr_cnt, 0);
        chk("t5_one_pop", pops, 1);
        chk("t5_valid", {31'd0, o_valid}, 1);
        i_ready = 1'b1;
        idle(8);
        chk("t5_pops", pops, 5);
        chk("t5_drained", {31'd0, o_valid}, 0);
        chk("t5_sb_empty", exp_q.size(), 0);

        // Reset in the middle of data bit 4 with a byte already buffered.
        i_ready = 1'b0;
        send(8'h77, 1'b1, -1, 80);
        idle(2);
        chk("t6_pre_valid", {31'd0, o_valid}, 1);
        send(8'h96, 1'b1, -1, 44);
        rst = 1'b1;
        i_rx = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t6_valid", {31'd0, o_valid}, 0);
        chk("t6_data", {24'd0, o_data}, 0);
        chk("t6_busy", {31'd0, o_busy}, 0);
        chk("t6_ferr", {31'd0, o_frame_err}, 0);
        chk("t6_ovr", {31'd0, o_overrun}, 0);
        idle(4);
        i_ready = 1'b1;
        pops = 0;
        exp_q.push_back(8'h96);
        send(8'h96, 1'b1, -1, 80);
        idle(4);
        chk("t6_pops", pops, 1);
        chk("t6_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
